// File: rtl/mmc1_pkg.sv
// mmc1_pkg: shared encodings and widths for the MMC1 mapper blocks
package mmc1_pkg;
  localparam int SDRAM_AW = 23;
  localparam int BANK16_W = 4;
  localparam logic [4:0] CTRL_RESET = 5'h0C;
  typedef enum logic [1:0] {REG_CTRL, REG_CHR0, REG_CHR1, REG_PRG} reg_sel_e;
  typedef enum logic [1:0] {PRG_32K_A, PRG_32K_B, PRG_FIX_FIRST, PRG_FIX_LAST} prg_mode_e;
  typedef enum logic [1:0] {MIR_ONE_LO, MIR_ONE_HI, MIR_VERT, MIR_HORZ} mirror_e;
endpackage

// File: rtl/m2_sync.sv
// m2_sync: multi-flop synchroniser for CPU phi2 with level and edge strobes
module m2_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q;
  // shift the async pin through the synchroniser and remember the last synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end
  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = lvl_o & ~prev_q;
  assign fall_o = ~lvl_o & prev_q;
endmodule

// File: rtl/mmc1_mapper.sv
// mmc1_mapper: MMC1 serial-port bank mapper; define MMC1_CONSEC_IGNORE_EN to drop back-to-back ROM writes
module mmc1_mapper
  import mmc1_pkg::*;
#(
  parameter logic [SDRAM_AW-1:0] PRG_BASE = 23'h000000,
  parameter logic [SDRAM_AW-1:0] CHR_BASE = 23'h040000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [14:0]         cpu_addr,
  input  logic [7:0]          cpu_data_in,
  input  logic                cpu_rw,
  input  logic                cpu_rom_sel_n,
  input  logic                cpu_m2,
  input  logic [13:0]         ppu_addr,
  output logic [SDRAM_AW-1:0] prg_addr,
  output logic [SDRAM_AW-1:0] chr_addr,
  output logic                ciram_a10,
  output logic                prg_ram_ce,
  output logic                reg_wr
);
  logic m2_lvl, m2_fall;
  logic [1:0] hold_a_q;
  logic hold_d7_q, hold_d0_q, hold_wr_q;
  logic [3:0] shift_q, shift_d;
  logic [2:0] count_q, count_d;
  logic [4:0] ctrl_q, ctrl_d, chr0_q, chr0_d, chr1_q, chr1_d, prg_q, prg_d;
  logic reg_wr_d, consec_ok, wr_evt, rst_evt, ld_evt;
  logic [4:0] value;
  reg_sel_e sel;
  prg_mode_e mode;
  mirror_e mirror;
  logic [BANK16_W-1:0] bank16;
  logic [16:0] chr_off;
  logic [SDRAM_AW-1:0] prg_addr_d, chr_addr_d;
  logic a10_d, ce_d;

  m2_sync #(.SYNC_STAGES(SYNC_STAGES)) u_m2_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (cpu_m2),
    .lvl_o  (m2_lvl),
    .rise_o (),
    .fall_o (m2_fall)
  );

`ifdef MMC1_CONSEC_IGNORE_EN
  logic last_wr_q;
  // remember whether the previous completed bus cycle was a ROM-space write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_wr_q <= 1'b0;
    else if (m2_fall) last_wr_q <= hold_wr_q;
  end
  assign consec_ok = ~last_wr_q;
`else
  assign consec_ok = 1'b1;
`endif

  // keep only the bus fields the serial port needs, refreshed while phi2 is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a_q  <= '0;
      hold_d7_q <= 1'b0;
      hold_d0_q <= 1'b0;
      hold_wr_q <= 1'b0;
    end else if (m2_lvl) begin
      hold_a_q  <= cpu_addr[14:13];
      hold_d7_q <= cpu_data_in[7];
      hold_d0_q <= cpu_data_in[0];
      hold_wr_q <= ~cpu_rw & ~cpu_rom_sel_n;
    end
  end

  // serial port: reset bit, shift in d0, or commit the fifth bit to a register
  always_comb begin
    wr_evt   = m2_fall & hold_wr_q & consec_ok;
    rst_evt  = wr_evt & hold_d7_q;
    ld_evt   = wr_evt & ~hold_d7_q & (count_q == 3'd4);
    value    = {hold_d0_q, shift_q};
    sel      = reg_sel_e'(hold_a_q);
    shift_d  = (rst_evt | ld_evt) ? 4'h0 : wr_evt ? {hold_d0_q, shift_q[3:1]} : shift_q;
    count_d  = (rst_evt | ld_evt) ? 3'd0 : wr_evt ? count_q + 3'd1 : count_q;
    ctrl_d   = rst_evt ? (ctrl_q | CTRL_RESET) : (ld_evt && sel == REG_CTRL) ? value : ctrl_q;
    chr0_d   = (ld_evt && sel == REG_CHR0) ? value : chr0_q;
    chr1_d   = (ld_evt && sel == REG_CHR1) ? value : chr1_q;
    prg_d    = (ld_evt && sel == REG_PRG) ? value : prg_q;
    reg_wr_d = ld_evt;
  end

  // bank translation and mirroring from the current register contents
  always_comb begin
    mode       = prg_mode_e'(ctrl_q[3:2]);
    mirror     = mirror_e'(ctrl_q[1:0]);
    bank16     = mode == PRG_FIX_FIRST ? (cpu_addr[14] ? prg_q[3:0] : 4'h0) :
                 mode == PRG_FIX_LAST  ? (cpu_addr[14] ? 4'hF : prg_q[3:0]) :
                 {prg_q[3:1], cpu_addr[14]};
    chr_off    = ctrl_q[4] ? {ppu_addr[12] ? chr1_q : chr0_q, ppu_addr[11:0]} :
                 {chr0_q[4:1], ppu_addr[12:0]};
    prg_addr_d = PRG_BASE + SDRAM_AW'({bank16, cpu_addr[13:0]});
    chr_addr_d = CHR_BASE + SDRAM_AW'(chr_off);
    a10_d      = mirror == MIR_VERT ? ppu_addr[10] : mirror == MIR_HORZ ? ppu_addr[11] :
                 (mirror == MIR_ONE_HI);
    ce_d       = m2_lvl & cpu_rom_sel_n & (cpu_addr[14:13] == 2'b11) & ~prg_q[4];
  end

  // mapper registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      count_q    <= '0;
      ctrl_q     <= CTRL_RESET;
      chr0_q     <= '0;
      chr1_q     <= '0;
      prg_q      <= '0;
      reg_wr     <= 1'b0;
      prg_addr   <= '0;
      chr_addr   <= '0;
      ciram_a10  <= 1'b0;
      prg_ram_ce <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      count_q    <= count_d;
      ctrl_q     <= ctrl_d;
      chr0_q     <= chr0_d;
      chr1_q     <= chr1_d;
      prg_q      <= prg_d;
      reg_wr     <= reg_wr_d;
      prg_addr   <= prg_addr_d;
      chr_addr   <= chr_addr_d;
      ciram_a10  <= a10_d;
      prg_ram_ce <= ce_d;
    end
  end
endmodule

// File: tb/tb_mmc1_mapper.sv
// tb_mmc1_mapper: scoreboard bench for the MMC1 mapper (directed vectors)
module tb_mmc1_mapper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [14:0] cpu_addr = '0;
  logic [7:0] cpu_data_in = '0;
  logic cpu_rw = 1'b1, cpu_rom_sel_n = 1'b1, cpu_m2 = 1'b0;
  logic [13:0] ppu_addr = '0;
  logic [22:0] prg_addr, chr_addr;
  logic ciram_a10, prg_ram_ce, reg_wr;

  typedef struct {
    int          sel;
    logic [22:0] val;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic [22:0] act;
  int cyc = 0, checks = 0, failures = 0, rw_cnt = 0, exp_rw = 0;

  mmc1_mapper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_data_in   (cpu_data_in),
    .cpu_rw        (cpu_rw),
    .cpu_rom_sel_n (cpu_rom_sel_n),
    .cpu_m2        (cpu_m2),
    .ppu_addr      (ppu_addr),
    .prg_addr      (prg_addr),
    .chr_addr      (chr_addr),
    .ciram_a10     (ciram_a10),
    .prg_ram_ce    (prg_ram_ce),
    .reg_wr        (reg_wr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: count reg_wr pulses, then retire every expectation that is due
  always @(negedge clk) begin
    if (reg_wr === 1'b1) rw_cnt = rw_cnt + 1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.sel)
        0: act = prg_addr;
        1: act = chr_addr;
        2: act = {22'b0, ciram_a10};
        3: act = {22'b0, prg_ram_ce};
        default: act = 23'(rw_cnt);
      endcase
      checks = checks + 1;
      if (act !== e.val) begin
        failures = failures + 1;
        $display("FAIL %s: got %h expected %h", e.name, act, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input logic [22:0] v, input string n);
    sb.push_back('{sel, v, cyc + 1, n});
    tick(2);
  endtask

  task automatic chk_now(input int sel, input logic [22:0] v, input string n);
    sb.push_back('{sel, v, cyc, n});
    tick(1);
  endtask

  task automatic bus(input logic [14:0] a, input logic [7:0] d, input logic rw, input logic rsn);
    cpu_addr = a;
    cpu_data_in = d;
    cpu_rw = rw;
    cpu_rom_sel_n = rsn;
    cpu_m2 = 1'b1;
    tick(4);
    cpu_m2 = 1'b0;
    tick(6);
    cpu_rw = 1'b1;
    cpu_rom_sel_n = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a[14:0], d, 1'b0, 1'b0);
`ifdef MMC1_CONSEC_IGNORE_EN
    bus(a[14:0], 8'h00, 1'b1, 1'b0);
`endif
  endtask

  task automatic load(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) wr(a, {7'b0, v[i]});
  endtask

  initial begin
    tick(2);
    chk_now(0, 23'h0, "reset_prg_addr");
    chk_now(1, 23'h0, "reset_chr_addr");
    chk_now(2, 23'h0, "reset_a10");
    chk_now(3, 23'h0, "reset_ce");
    chk_now(4, 23'h0, "reset_reg_wr");
    rst_n = 1'b1;
    cpu_addr = 15'h4000;
    chk(0, 23'h03C000, "prg_mode3_last_bank");
    chk(1, 23'h040000, "chr_after_reset");
    chk(2, 23'h0, "a10_after_reset");
    load(16'hE000, 5'h05);
    exp_rw++;
    cpu_addr = 15'h0000;
    chk(0, 23'h014000, "prg_mode3_bank5");
    chk(4, 23'(exp_rw), "reg_wr_once");
    for (int i = 0; i < 3; i++) wr(16'h8000, 8'h01);
    wr(16'h8000, 8'h80);
    chk(4, 23'(exp_rw), "no_reg_wr_on_reset_bit");
    load(16'h8000, 5'h00);
    exp_rw++;
    ppu_addr = 14'h2400;
    chk(2, 23'h0, "a10_one_lo_2400");
    ppu_addr = 14'h2C00;
    chk(2, 23'h0, "a10_one_lo_2c00");
    cpu_addr = 15'h4000;
    chk(0, 23'h014000, "prg_32k_hi");
    cpu_addr = 15'h0000;
    chk(0, 23'h010000, "prg_32k_lo");
    load(16'h8000, 5'h10);
    load(16'hA000, 5'h03);
    load(16'hC000, 5'h07);
    exp_rw += 3;
    ppu_addr = 14'h1123;
    chk(1, 23'h047123, "chr4k_hi_chr1");
    ppu_addr = 14'h0123;
    chk(1, 23'h043123, "chr4k_lo_chr0");
    load(16'h8000, 5'h02);
    exp_rw++;
    ppu_addr = 14'h1123;
    chk(1, 23'h043123, "chr8k_mode");
    ppu_addr = 14'h2400;
    chk(2, 23'h1, "a10_vert_2400");
    ppu_addr = 14'h2800;
    chk(2, 23'h0, "a10_vert_2800");
    load(16'h8000, 5'h03);
    exp_rw++;
    chk(2, 23'h1, "a10_horz_2800");
    ppu_addr = 14'h2400;
    chk(2, 23'h0, "a10_horz_2400");
    load(16'h8000, 5'h08);
    exp_rw++;
    cpu_addr = 15'h0123;
    chk(0, 23'h000123, "prg_mode2_fixed_first");
    cpu_addr = 15'h4123;
    chk(0, 23'h014123, "prg_mode2_switch_hi");
    chk(4, 23'(exp_rw), "reg_wr_count_mid");
    cpu_addr = 15'h6000;
    cpu_rom_sel_n = 1'b1;
    cpu_m2 = 1'b1;
    tick(4);
    chk(3, 23'h1, "prg_ram_ce_on");
    cpu_m2 = 1'b0;
    tick(4);
    chk(3, 23'h0, "prg_ram_ce_m2_low");
    load(16'hE000, 5'h15);
    exp_rw++;
    cpu_addr = 15'h6000;
    cpu_m2 = 1'b1;
    tick(4);
    chk(3, 23'h0, "prg_ram_ce_disabled");
    cpu_m2 = 1'b0;
    tick(6);
    wr(16'hA000, 8'h01);
    wr(16'hA000, 8'h01);
    rst_n = 1'b0;
    chk_now(0, 23'h0, "prg_addr_in_reset");
    tick(2);
    rst_n = 1'b1;
    load(16'hA000, 5'h02);
    exp_rw++;
    ppu_addr = 14'h0000;
    chk(1, 23'h042000, "chr0_fresh_after_reset");
    chk(4, 23'(exp_rw), "reg_wr_after_reset");
`ifdef MMC1_CONSEC_IGNORE_EN
    bus(15'h6000, 8'h01, 1'b0, 1'b0);
    bus(15'h6000, 8'h00, 1'b0, 1'b0);
    bus(15'h6000, 8'h00, 1'b1, 1'b0);
    wr(16'hE000, 8'h01);
    wr(16'hE000, 8'h00);
    wr(16'hE000, 8'h00);
    wr(16'hE000, 8'h00);
    exp_rw++;
    cpu_addr = 15'h0000;
    chk(0, 23'h00C000, "consec_write_ignored");
    chk(4, 23'(exp_rw), "consec_reg_wr");
`endif
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
